// File: rtl/dff_pipeline_pkg.sv
// Shared width helpers for the dff_pipeline register chain.
package dff_pipeline_pkg;

    // Width of the tap select port; a single-stage pipeline still gets a 1-bit port.
    function automatic int unsigned tap_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the fill counter, wide enough to hold the value depth itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_en_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with async reset,
// synchronous clear (priority over enable) and shift enable.
module dff_en_stage #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Stage register: clear beats enable; data shifts regardless of valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else if (clr) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else if (en) begin
            data_q  <= d;
            valid_q <= d_valid;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage enabled register pipeline with flush, per-stage valid, runtime
// tap, fill count and optional edge detect on the output.
// Optional feature macro: DFF_PIPELINE_EDGE_EN (adds the q_prev register and
// drives rise/fall; otherwise rise/fall are tied low).
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    input  logic [tap_width(DEPTH)-1:0]  tap_sel,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [WIDTH-1:0]             q_tap,
    output logic [cnt_width(DEPTH)-1:0]  fill_cnt,
    output logic                         full,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            dff_en_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clock   (clock),
                .reset   (reset),
                .en      (en),
                .clr     (clr),
                .d       (d),
                .d_valid (d_valid),
                .q       (stage_data[0]),
                .q_valid (stage_valid[0])
            );
        end else begin : g_rest
            dff_en_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clock   (clock),
                .reset   (reset),
                .en      (en),
                .clr     (clr),
                .d       (stage_data[i-1]),
                .d_valid (stage_valid[i-1]),
                .q       (stage_data[i]),
                .q_valid (stage_valid[i])
            );
        end
    end

    assign q       = stage_data[DEPTH-1];
    assign q_valid = stage_valid[DEPTH-1];

    // Fill count tracks valid samples entering minus leaving; it cannot exceed DEPTH
    // because a full pipeline always has q_valid set.
    logic [CW-1:0] fill_q, fill_d;

    // Next fill count for an enabled shift.
    always_comb begin
        fill_d = fill_q + CW'(d_valid) - CW'(q_valid);
    end

    // Fill counter register, cleared together with the stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else if (clr) begin
            fill_q <= '0;
        end else if (en) begin
            fill_q <= fill_d;
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == CW'(DEPTH));

    if (DEPTH == 1) begin : g_tap_single
        logic unused_tap_sel;
        assign unused_tap_sel = ^tap_sel;
        assign q_tap          = stage_data[0];
    end else begin : g_tap_mux
        // Tap mux; out-of-range selects fall back to the last stage.
        always_comb begin
            q_tap = stage_data[DEPTH-1];
            if (32'(tap_sel) < DEPTH) begin
                q_tap = stage_data[tap_sel];
            end
        end
    end

`ifdef DFF_PIPELINE_EDGE_EN
    logic [WIDTH-1:0] q_prev;

    // Previous output sample, advanced only on enabled shifts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_prev <= RESET_VAL;
        end else if (clr) begin
            q_prev <= RESET_VAL;
        end else if (en) begin
            q_prev <= q;
        end
    end

    assign rise = q & ~q_prev & {WIDTH{q_valid}};
    assign fall = ~q & q_prev & {WIDTH{q_valid}};
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
